inst_fetch_resp: RTL
====================

INST_FETCH_RESP -- requirements
Module: inst_fetch_resp

Interface
REQ-001 Parameter: `INIT_PC`, default `` `INIT_PC ``, the address driven on mem_addr and inst_pc out of reset.
REQ-002 Port: `clk`, input, 1, sole clock; all state changes on the posedge.
REQ-003 Port: `rst`, input, 1, synchronous, active-low reset.
REQ-004 Ports from the PC side:
- `rom_en`, input, 1, fetch request enable.
- `rom_write_en`, input, 4, byte write enables; ignored.
- `rom_addr`, input, `` `ADDR_BUS ``, fetch address.
- `rom_write_data`, input, `` `DATA_BUS ``, write data; ignored.
REQ-005 Ports `flush` (input, 1, pipeline flush) and `stall_pc` (input, 1, downstream stall).
REQ-006 Port `stall_req`, output, 1, holds the PC while a fetch is outstanding.
REQ-007 Ports to ID:
- `inst`, output, `` `DATA_BUS ``, instruction.
- `inst_pc`, output, `` `ADDR_BUS ``, address of `inst`.
- `inst_valid`, output, 1, `inst`/`inst_pc` are meaningful.
- `inst_exc_adel`, output, 1, misaligned fetch.
REQ-008 Memory-side ports:
- `mem_req`, output, 1, request.
- `mem_addr`, output, `` `ADDR_BUS ``, word address.
- `mem_addr_ok`, input, 1, request accepted.
- `mem_data_ok`, input, 1, read data valid.
- `mem_rdata`, input, `` `DATA_BUS ``, read data.

Function
REQ-009 FSM states: IDLE, REQ, WAIT, HOLD, DISCARD; one registered state variable.
REQ-010 IDLE, rom_en=1, flush=0, rom_addr[1:0]=0: latch rom_addr into mem_addr and inst_pc; next state REQ.
REQ-011 IDLE, rom_en=1, flush=0, rom_addr[1:0]!=0:
- No memory request is issued.
- Next cycle: inst_valid=1, inst_exc_adel=1, inst=0, inst_pc=rom_addr, for one cycle.
- Then behaves like REQ-015/016 (HOLD if stall_pc).
REQ-012 REQ: mem_req=1 with a stable mem_addr.
- mem_req deasserts only after a cycle with mem_addr_ok=1; it is never withdrawn early, including on flush.
- On mem_addr_ok=1, next state WAIT (or DISCARD if a flush is pending).
REQ-013 WAIT: mem_req=0; wait for mem_data_ok, with no timeout.
REQ-014 On mem_data_ok=1 in WAIT:
- Register mem_rdata into inst.
- inst_valid=1 in the next cycle.
- inst_exc_adel=0.
REQ-015 After a data return with stall_pc=0: inst_valid is a single-cycle pulse; state returns to IDLE.
REQ-016 After a data return with stall_pc=1: next state HOLD. In HOLD:
- inst, inst_pc and inst_valid=1 are held.
- The cycle after stall_pc falls, inst_valid=0 and state is IDLE.
REQ-017 stall_req (combinational) =1 from the cycle a request is accepted (REQ-010) through WAIT; it is 0 in the cycle mem_data_ok=1.
REQ-018 stall_req =1 in DISCARD; it is 0 in IDLE (when no request is accepted) and in HOLD.
REQ-019 flush has priority over all other inputs.
REQ-020 flush in IDLE: no request is accepted.
REQ-021 flush in REQ: set a discard flag; after mem_addr_ok, go to DISCARD.
REQ-022 flush in WAIT: go to DISCARD, unless mem_data_ok=1 in the same cycle, in which case the data is dropped and state goes to IDLE.
REQ-023 flush in HOLD: go to IDLE.
REQ-024 Every flush clears inst_valid at the next edge.
REQ-025 DISCARD: on mem_data_ok, drop the data (inst_valid stays 0) and go to IDLE; the discard flag clears.
REQ-026 Writes are never issued; rom_write_en and rom_write_data have no effect.
REQ-027 At most one outstanding memory transaction at any time.

Reset
REQ-028 rst=0 at a posedge applies the reset values, including mid-transaction:
- state=IDLE, discard flag=0.
- mem_req=0, mem_addr=INIT_PC.
- inst=0, inst_pc=INIT_PC.
- inst_valid=0, inst_exc_adel=0, stall_req=0.
REQ-029 A response arriving after reset is ignored (mem_data_ok in IDLE has no effect).

Structure
REQ-030 `` `ADDR_BUS ``, `` `DATA_BUS `` and `` `INIT_PC `` come from the shared bus include.
REQ-031 The state encodings and the ADEL exception code live in the shared exception/bus includes, not local literals.
REQ-032 Single flat module; no sub-module.

Verification
REQ-033 Basic fetch: rom_addr=0xBFC00000, addr_ok in cycle 1, data_ok with rdata=0x24080001 in cycle 3 -> inst_valid pulse with inst=0x24080001, inst_pc=0xBFC00000; stall_req=1 for cycles 0-2.
REQ-034 Misaligned fetch: rom_addr=0xBFC00002 -> mem_req never 1; inst_valid=1, inst_exc_adel=1, inst_pc=0xBFC00002.
REQ-035 Flush during REQ: flush while addr_ok is held low 3 cycles -> mem_req stays 1 until addr_ok; the returned data 0xDEADBEEF is never presented; state reaches IDLE after data_ok.
REQ-036 Stall hold: data returns while stall_pc=1 for 4 cycles -> inst/inst_valid held 4 cycles, inst_valid=0 the cycle after stall_pc falls.
REQ-037 Simultaneous events and reset:
- flush with data_ok in the same cycle -> inst_valid stays 0.
- rst=0 during WAIT -> all outputs at reset values next cycle; a late data_ok is ignored.

Source files
------------

// File: rtl/inst_fetch_resp_pkg.sv
// ============================================================================
// Module : inst_fetch_resp_pkg
// Brief  : Shared bus widths, reset PC and fetch FSM state encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package inst_fetch_resp_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] INIT_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DISCARD = 3'd4
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_resp.sv
// ============================================================================
// Module : inst_fetch_resp
// Brief  : Instruction fetch bridge between the PC stage and a split
//          request/response memory port, with flush, stall and ADEL handling.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
#(
    parameter logic [ADDR_W-1:0] INIT_PC = INIT_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              rom_en,
    input  logic [3:0]        rom_write_en,
    input  logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_write_data,

    input  logic              flush,
    input  logic              stall_pc,
    output logic              stall_req,

    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    output logic              inst_exc_adel,

    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nx;
    logic              r_discard;
    logic              w_discard_nx;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [ADDR_W-1:0] w_pc_nx;
    logic [DATA_W-1:0] w_inst_nx;
    logic              w_valid_nx;
    logic              w_adel_nx;

    // The write side of the port is read-only instruction memory.
    logic w_unused_write;
    assign w_unused_write = ^{rom_write_en, rom_write_data};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_discard     <= 1'b0;
            mem_addr      <= INIT_PC;
            inst_pc       <= INIT_PC;
            inst          <= '0;
            inst_valid    <= 1'b0;
            inst_exc_adel <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_discard     <= w_discard_nx;
            mem_addr      <= w_addr_nx;
            inst_pc       <= w_pc_nx;
            inst          <= w_inst_nx;
            inst_valid    <= w_valid_nx;
            inst_exc_adel <= w_adel_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_discard_nx = r_discard;
        w_addr_nx    = mem_addr;
        w_pc_nx      = inst_pc;
        w_inst_nx    = inst;
        w_valid_nx   = inst_valid;
        w_adel_nx    = inst_exc_adel;
        stall_req    = 1'b0;
        mem_req      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_valid_nx = 1'b0;
                w_adel_nx  = 1'b0;
                if (rom_en && !flush) begin
                    if (rom_addr[1:0] == 2'b00) begin
                        w_addr_nx  = rom_addr;
                        w_pc_nx    = rom_addr;
                        w_state_nx = ST_REQ;
                        stall_req  = 1'b1;
                    end else begin
                        // Misaligned: report ADEL locally, never touch memory.
                        w_pc_nx    = rom_addr;
                        w_inst_nx  = '0;
                        w_valid_nx = 1'b1;
                        w_adel_nx  = 1'b1;
                        w_state_nx = stall_pc ? ST_HOLD : ST_IDLE;
                    end
                end
            end

            ST_REQ: begin
                mem_req   = 1'b1;
                stall_req = 1'b1;
                if (flush) begin
                    w_discard_nx = 1'b1;
                end
                if (mem_addr_ok) begin
                    w_state_nx = (r_discard || flush) ? ST_DISCARD : ST_WAIT;
                end
            end

            ST_WAIT: begin
                stall_req = !mem_data_ok;
                if (flush) begin
                    w_state_nx = mem_data_ok ? ST_IDLE : ST_DISCARD;
                end else if (mem_data_ok) begin
                    w_inst_nx  = mem_rdata;
                    w_valid_nx = 1'b1;
                    w_adel_nx  = 1'b0;
                    w_state_nx = stall_pc ? ST_HOLD : ST_IDLE;
                end
            end

            ST_HOLD: begin
                if (flush || !stall_pc) begin
                    w_valid_nx = 1'b0;
                    w_adel_nx  = 1'b0;
                    w_state_nx = ST_IDLE;
                end
            end

            ST_DISCARD: begin
                stall_req  = 1'b1;
                w_valid_nx = 1'b0;
                if (mem_data_ok) begin
                    w_discard_nx = 1'b0;
                    w_state_nx   = ST_IDLE;
                end
            end

            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        if (flush) begin
            w_valid_nx = 1'b0;
            w_adel_nx  = 1'b0;
        end
    end

endmodule

`default_nettype wire
